// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch front end
// Contents:
//   fetch_state_e : sequencer state (IDLE, RUN, FAULT)
//   fetch_entry_t : one fetched instruction with the PC it came from
//   INSTR_BYTES   : bytes per instruction word
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small FIFO of fetched {pc, instr} entries
// Parameters:
//   QDEPTH    : entries, power of two, >= 2
// Ports:
//   clk       : clock, all updates on posedge
//   reset_n   : synchronous active-low reset, empties the FIFO
//   push      : write push_data at the tail
//   push_data : entry to write
//   pop       : drop the head entry
//   flush     : empty the FIFO, wins over push and pop
//   full      : no free entry
//   empty     : no valid entry
//   head      : oldest entry, zero while empty
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int QDEPTH = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   input  logic         flush,
   output logic         full,
   output logic         empty,
   output fetch_entry_t head
);

   localparam int AW = $clog2(QDEPTH);

   // Index bits plus one wrap bit: equal index with differing wrap bits means full.
   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   fetch_entry_t mem_q [QDEPTH];
   fetch_entry_t mem_d [QDEPTH];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         // A push while full is only issued together with a pop; the slot
         // written is the one being popped, whose old value is read this cycle.
         if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
      mem_q <= mem_d;
   end

   always_comb begin
      empty = (wr_ptr_q == rd_ptr_q);
      full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
      head  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC sequencer and instruction fetch front end
// Build option: FETCH_TARGET_CHECK_EN enables redirect target checking and the FAULT state.
// Parameters:
//   MEM_BYTES  : ROM size in bytes (power of two, > 4)
//   RESET_PC   : word-aligned PC loaded on reset
//   QDEPTH     : fetch FIFO entries
// Ports:
//   clk, reset_n          : clock, synchronous active-low reset
//   start                 : leave IDLE and begin fetching
//   imem_addr, imem_instr : ROM address (registered PC) and same-cycle read data
//   br_valid, br_target   : redirect pulse and target byte address
//   out_valid, out_ready  : decode handshake on the FIFO head
//   out_instr, out_pc     : head instruction and its PC
//   busy                  : sequencer is in RUN
//   fault, fault_pc       : sticky bad-target flag and the target that caused it
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int          MEM_BYTES = 1024,
   parameter logic [63:0] RESET_PC  = 64'd0,
   parameter int          QDEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   output logic [63:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        br_valid,
   input  logic [63:0] br_target,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [63:0] out_pc,
   output logic        busy,
   output logic        fault,
   output logic [63:0] fault_pc
);

   fetch_state_e state_q, state_d;
   logic [63:0]  pc_q, pc_d;
   logic         fifo_full, fifo_empty;
   fetch_entry_t fifo_head;
   fetch_entry_t push_entry;
   logic         redirect, pc_at_end, pop, do_fetch;

   // 65-bit compare so a PC near the top of the address space cannot wrap back in range.
   assign pc_at_end = ({1'b0, pc_q} + 65'(INSTR_BYTES - 1)) >= 65'(MEM_BYTES);
   assign redirect  = (state_q == RUN) && br_valid;
   assign pop       = !fifo_empty && out_ready;
   assign do_fetch  = (state_q == RUN) && !br_valid && !pc_at_end && (!fifo_full || pop);

   assign push_entry.pc    = pc_q;
   assign push_entry.instr = imem_instr;

`ifdef FETCH_TARGET_CHECK_EN
   logic        tgt_bad;
   logic        fault_q, fault_d;
   logic [63:0] fault_pc_q, fault_pc_d;

   assign tgt_bad = (br_target[1:0] != 2'b00) ||
                    (({1'b0, br_target} + 65'(INSTR_BYTES - 1)) >= 65'(MEM_BYTES));

   always_comb begin
      fault_d    = fault_q;
      fault_pc_d = fault_pc_q;
      if (redirect && tgt_bad) begin
         fault_d    = 1'b1;
         fault_pc_d = br_target;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fault_q    <= 1'b0;
         fault_pc_q <= '0;
      end else begin
         fault_q    <= fault_d;
         fault_pc_q <= fault_pc_d;
      end
   end

   assign fault    = fault_q;
   assign fault_pc = fault_pc_q;

   always_ff @(posedge clk) begin
      if (reset_n && redirect && tgt_bad) begin
         $error("%t: fetch redirect to bad target %h", $time, br_target);
      end
   end
`else
   assign fault    = 1'b0;
   assign fault_pc = '0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = RUN;
`ifdef FETCH_TARGET_CHECK_EN
         RUN:  if (redirect && tgt_bad) state_d = FAULT;
`else
         RUN:  state_d = RUN;
`endif
         FAULT: state_d = FAULT;
         default: state_d = IDLE;
      endcase
   end

   // Output logic.
   always_comb begin
      busy      = (state_q == RUN);
      imem_addr = pc_q;
      out_valid = !fifo_empty;
      out_pc    = fifo_head.pc;
      out_instr = fifo_head.instr;
   end

   // PC update: a redirect beats a fetch; a faulting redirect leaves the PC alone.
   always_comb begin
      pc_d = pc_q;
      if (redirect) begin
`ifdef FETCH_TARGET_CHECK_EN
         if (!tgt_bad) pc_d = br_target;
`else
         pc_d = br_target & ~64'(INSTR_BYTES - 1);
`endif
      end else if (do_fetch) begin
         pc_d = pc_q + 64'(INSTR_BYTES);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   // Redirect flushes the FIFO, which also discards any same-cycle pop.
   fetch_fifo #(
      .QDEPTH (QDEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (do_fetch),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (redirect),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (fifo_head)
   );

   always_ff @(posedge clk) begin
      if (reset_n) begin
         assert (!busy || (imem_addr[1:0] == 2'b00))
            else $error("%t: unaligned fetch address %h", $time, imem_addr);
         assert (!((state_q == FAULT) && out_valid))
            else $error("%t: out_valid asserted in FAULT", $time);
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer with a behavioural ROM
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [63:0] imem_addr;
   logic [31:0] imem_instr;
   logic        br_valid;
   logic [63:0] br_target;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [63:0] out_pc;
   logic        busy;
   logic        fault;
   logic [63:0] fault_pc;

   int          total = 0;
   int          bad   = 0;
   logic [95:0] sb [$];
   logic [95:0] sb_e;

   always #5 clk = ~clk;

   fetch_sequencer #(
      .MEM_BYTES (1024),
      .RESET_PC  (64'd0),
      .QDEPTH    (2)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .imem_addr  (imem_addr),
      .imem_instr (imem_instr),
      .br_valid   (br_valid),
      .br_target  (br_target),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_instr  (out_instr),
      .out_pc     (out_pc),
      .busy       (busy),
      .fault      (fault),
      .fault_pc   (fault_pc)
   );

   function automatic logic [31:0] rom_word(input logic [63:0] a);
      if (a < 64'd1024) return {8'hE5, 16'h0000, a[9:2]};
      return 32'hDEAD_BEEF;
   endfunction

   assign imem_instr = rom_word(imem_addr);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_pc(input logic [63:0] pc);
      sb.push_back({pc, rom_word(pc)});
   endtask

   // Monitor: every accepted head must match the next expected entry; handshakes
   // in a redirect cycle are discarded by the flush and are not deliveries.
   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready && !br_valid) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected: got pc %h expected no delivery", out_pc);
         end else begin
            sb_e = sb.pop_front();
            check("sb_pc", out_pc, sb_e[95:32]);
            check("sb_instr", {32'h0, out_instr}, {32'h0, sb_e[31:0]});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n   = 1'b0;
      start     = 1'b0;
      br_valid  = 1'b0;
      br_target = '0;
      out_ready = 1'b1;
      tick();
      tick();
      check("rst_out_valid", {63'h0, out_valid}, 64'd0);
      check("rst_busy", {63'h0, busy}, 64'd0);
      check("rst_imem_addr", imem_addr, 64'd0);
      check("rst_out_pc", out_pc, 64'd0);
      check("rst_out_instr", {32'h0, out_instr}, 64'd0);
      check("rst_fault", {63'h0, fault}, 64'd0);
      check("rst_fault_pc", fault_pc, 64'd0);
      reset_n = 1'b1;
      tick();

      // Streaming with out_ready high: four deliveries at pc 0,4,8,12.
      for (int i = 0; i < 4; i++) expect_pc(64'(i * 4));
      start = 1'b1;
      tick();
      start = 1'b0;
      check("s1_busy", {63'h0, busy}, 64'd1);
      check("s1_valid_early", {63'h0, out_valid}, 64'd0);
      tick();
      check("s1_valid_rise", {63'h0, out_valid}, 64'd1);
      check("s1_first_pc", out_pc, 64'd0);
      check("s1_first_instr", {32'h0, out_instr}, {32'h0, rom_word(64'd0)});
      for (int i = 0; i < 4; i++) begin
         tick();
         check("s1_stream_valid", {63'h0, out_valid}, 64'd1);
      end
      out_ready = 1'b0;
      tick();
      tick();
      check("s1_drained", 64'(sb.size()), 64'd0);

      // One-cycle reset in the middle of a run.
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check("s6_out_valid", {63'h0, out_valid}, 64'd0);
      check("s6_busy", {63'h0, busy}, 64'd0);
      check("s6_imem_addr", imem_addr, 64'd0);
      check("s6_out_pc", out_pc, 64'd0);
      repeat (3) tick();
      check("s6_idle_busy", {63'h0, busy}, 64'd0);
      check("s6_idle_addr", imem_addr, 64'd0);
      check("s6_idle_valid", {63'h0, out_valid}, 64'd0);

      // Backpressure: FIFO fills with pc 0 and 4, fetch stalls at 8.
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      check("s2_stall_addr", imem_addr, 64'd8);
      check("s2_stall_valid", {63'h0, out_valid}, 64'd1);
      check("s2_stall_head", out_pc, 64'd0);
      for (int i = 0; i < 4; i++) expect_pc(64'(i * 4));
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("s2_no_gap", {63'h0, out_valid}, 64'd1);
      end
      out_ready = 1'b0;
      tick();
      check("s2_hold_addr", imem_addr, 64'd24);
      check("s2_hold_head", out_pc, 64'd16);
      check("s2_drained", 64'(sb.size()), 64'd0);

      // Redirect to 0x40 with a full FIFO: both entries dropped.
      expect_pc(64'h40);
      expect_pc(64'h44);
      br_valid  = 1'b1;
      br_target = 64'h40;
      out_ready = 1'b1;
      tick();
      br_valid = 1'b0;
      check("s3_flushed", {63'h0, out_valid}, 64'd0);
      check("s3_pc_loaded", imem_addr, 64'h40);
      tick();
      check("s3_valid", {63'h0, out_valid}, 64'd1);
      check("s3_first_pc", out_pc, 64'h40);
      tick();
      tick();
      out_ready = 1'b0;
      tick();
      tick();
      check("s3_drained", 64'(sb.size()), 64'd0);

      // Redirect to the last ROM word: one delivery, then end of ROM.
      expect_pc(64'h3FC);
      br_valid  = 1'b1;
      br_target = 64'h3FC;
      out_ready = 1'b1;
      tick();
      br_valid = 1'b0;
      tick();
      check("s4_last_pc", out_pc, 64'h3FC);
      check("s4_last_valid", {63'h0, out_valid}, 64'd1);
      check("s4_addr_end", imem_addr, 64'h400);
      repeat (6) tick();
      check("s4_end_valid", {63'h0, out_valid}, 64'd0);
      check("s4_end_addr", imem_addr, 64'h400);
      check("s4_end_busy", {63'h0, busy}, 64'd1);
      check("s4_drained", 64'(sb.size()), 64'd0);

      // Unaligned redirect target 0x42.
`ifdef FETCH_TARGET_CHECK_EN
      br_valid  = 1'b1;
      br_target = 64'h42;
      tick();
      br_valid = 1'b0;
      check("s5_fault", {63'h0, fault}, 64'd1);
      check("s5_fault_pc", fault_pc, 64'h42);
      check("s5_busy", {63'h0, busy}, 64'd0);
      check("s5_valid", {63'h0, out_valid}, 64'd0);
      check("s5_pc_held", imem_addr, 64'h400);
      repeat (2) tick();
      check("s5_fault_valid", {63'h0, out_valid}, 64'd0);
      check("s5_fault_sticky", {63'h0, fault}, 64'd1);
`else
      expect_pc(64'h40);
      br_valid  = 1'b1;
      br_target = 64'h42;
      tick();
      br_valid = 1'b0;
      check("s5_aligned_addr", imem_addr, 64'h40);
      tick();
      check("s5_next_pc", out_pc, 64'h40);
      check("s5_next_valid", {63'h0, out_valid}, 64'd1);
      check("s5_fault", {63'h0, fault}, 64'd0);
      check("s5_fault_pc", fault_pc, 64'd0);
      tick();
      out_ready = 1'b0;
      tick();
      check("s5_drained", 64'(sb.size()), 64'd0);

      // Out-of-range target simply parks at the end of ROM.
      br_valid  = 1'b1;
      br_target = 64'h1000;
      tick();
      br_valid = 1'b0;
      repeat (3) tick();
      check("s5_oob_addr", imem_addr, 64'h1000);
      check("s5_oob_valid", {63'h0, out_valid}, 64'd0);
      check("s5_oob_busy", {63'h0, busy}, 64'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- PC sequencer and instruction-fetch front end for the 64-bit ARM-subset core.
- Drives the byte address into the combinational instruction ROM (1024 B, 32-bit words, word-aligned).
- Captures each returned word with its PC into a small FIFO and hands {pc, instr} to decode over a valid/ready handshake.
- Accepts branch redirects from execute, flushing in-flight fetches.

Parameters:
- MEM_BYTES, 1024: ROM size in bytes; power of two, >4.
- RESET_PC, 64'd0: PC loaded on reset; must be word-aligned.
- QDEPTH, 2: fetch FIFO entries; power of two, >=2.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  begin fetching; sampled in IDLE only.
- imem_addr  out  64  byte address to ROM; equals PC register, purely registered.
- imem_instr  in  32  ROM read data for imem_addr, combinational same cycle.
- br_valid  in  1  redirect request, single-cycle pulse.
- br_target  in  64  redirect byte address.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  decode accepts head.
- out_instr  out  32  head instruction.
- out_pc  out  64  head PC.
- busy  out  1  state==RUN.
- fault  out  1  sticky fault flag (feature-dependent).
- fault_pc  out  64  offending target address.

Behaviour:
- Reset (reset_n==0 at posedge; overrides everything, including mid-run):
  - state=IDLE, pc=RESET_PC, FIFO empty.
  - out_valid=0, busy=0, fault=0, fault_pc=0.
  - out_instr/out_pc=0 when FIFO empty.
- States: IDLE, RUN, FAULT.
  - IDLE: start=1 -> RUN next edge; no fetch, no push in IDLE.
  - RUN: stays until reset, or fault (feature on).
  - FAULT: absorbing until reset; no fetch, FIFO held empty.
- Fetch in RUN when all of:
  - pc+3 < MEM_BYTES (compared in 65-bit arithmetic, no wrap);
  - FIFO not full, or a pop occurs this cycle;
  - br_valid=0.
  - Action on fetch: push {pc, imem_instr}, pc <= pc+4.
- End of ROM: when pc+3 >= MEM_BYTES, no push and pc holds. Remaining FIFO entries still drain. Only a redirect resumes fetching.
- Pop: out_valid && out_ready. Simultaneous push+pop when full is legal; occupancy stays unchanged.
- Redirect (br_valid=1 in RUN):
  - Next edge: FIFO flushed to empty (a same-cycle pop is discarded with it), pc <= br_target, no push that cycle.
  - First redirected instruction appears on out_* 2 cycles after br_valid is sampled.
  - br_valid is ignored in IDLE and FAULT.
- Latency:
  - start sampled at edge N -> busy=1 after N.
  - First push at edge N+1 -> out_valid=1 after N+1.
  - Steady-state throughput 1 instr/cycle with out_ready held high.
- FIFO:
  - Pointers are log2(QDEPTH) bits plus one wrap bit.
  - Full when pointers are equal with differing wrap bits; empty when pointers and wrap bits are equal.
  - Wrap-around is natural modulo QDEPTH.
- Assertions (simulation only):
  - imem_addr[1:0]==0 whenever busy.
  - out_valid is never asserted in FAULT.

Optional Feature:
- Macro: FETCH_TARGET_CHECK_EN.
- Defined: a redirect with br_target[1:0]!=0 or br_target+3 >= MEM_BYTES, when sampled, does all of:
  - state -> FAULT, fault=1, fault_pc=br_target;
  - FIFO flushed, pc unchanged;
  - $error printed with %t.
- Undefined:
  - br_target[1:0] is forced to 0 before loading pc.
  - An out-of-bounds target loads pc and simply hits the end-of-ROM rule (no push).
  - fault and fault_pc are tied to 0.

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_e enum {IDLE, RUN, FAULT};
  - fetch_entry_t packed struct {logic [63:0] pc; logic [31:0] instr;};
  - localparam INSTR_BYTES=4.
- One sub-module, fetch_fifo, parameterised on QDEPTH and holding fetch_entry_t, with:
  - push/pop/flush inputs;
  - full/empty outputs;
  - head output.
- PC and FSM logic live in fetch_sequencer.

Test Plan:
- Reset, then start at cycle 1, ROM words 0..3 = A,B,C,D, out_ready=1: out_valid rises after edge 2; out_pc 0,4,8,12 with A..D on consecutive cycles.
- Hold out_ready=0 for 5 cycles after start (QDEPTH=2): FIFO holds pc 0 and 4, imem_addr stays 8. Release: sequence continues at 8 with no gap and no duplicate.
- br_valid with br_target=0x40 while FIFO holds 2 entries and out_ready=1: those entries are dropped; next out_pc=0x40 exactly 2 cycles later.
- Redirect to 0x3FC: one instruction with out_pc=0x3FC is delivered, then out_valid=0 and imem_addr stays 0x400 indefinitely.
- FETCH_TARGET_CHECK_EN defined, br_target=0x42: fault=1, fault_pc=0x42, busy=0, out_valid=0. Undefined: out_pc=0x40 next delivered.
- reset_n=0 for 1 cycle mid-stream: all outputs return to reset values; state=IDLE until start re-asserted.
